// File: rtl/multicycle_cpu_if.sv
// multicycle_cpu_if: instruction and data memory request/acknowledge bus.
interface multicycle_cpu_if #(
   parameter int DATA_W = 16,
   parameter int PC_W   = 13
);
   logic              imem_req;
   logic [PC_W-1:0]   imem_addr;
   logic              imem_ack;
   logic [15:0]       imem_rdata;
   logic              dmem_req;
   logic              dmem_we;
   logic [DATA_W-1:0] dmem_addr;
   logic [DATA_W-1:0] dmem_wdata;
   logic              dmem_ack;
   logic [DATA_W-1:0] dmem_rdata;
   modport master (
      output imem_req, imem_addr, dmem_req, dmem_we, dmem_addr, dmem_wdata,
      input  imem_ack, imem_rdata, dmem_ack, dmem_rdata
   );
   modport slave (
      input  imem_req, imem_addr, dmem_req, dmem_we, dmem_addr, dmem_wdata,
      output imem_ack, imem_rdata, dmem_ack, dmem_rdata
   );
endinterface

// File: rtl/multicycle_cpu.sv
// multicycle_cpu: 16-bit-encoded CPU sequenced FETCH/DECODE/EXEC/MEM/WB over handshaked memories.
module multicycle_cpu #(
   parameter int DATA_W     = 16,
   parameter int PC_W       = 13,
   parameter int BRANCH_REL = 0
) (
   input  logic                clk,
   input  logic                rst_n,
   multicycle_cpu_if.master    bus,
   output logic                halted,
   output logic                retire,
   output logic [31:0]         instret
);
   typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, WB, HALT} state_t;
   localparam logic [2:0] OP_R = 3'd0, OP_ADDI = 3'd1, OP_LW = 3'd2, OP_SW = 3'd3, OP_BEQ = 3'd4, OP_J = 3'd5;

   state_t            state, state_n;
   logic [15:0]       ir;
   logic [PC_W-1:0]   pc, pc_n, pc_inc, br_tgt;
   logic [DATA_W-1:0] a, b, res, alu, imm, rf_rs, rf_rt;
   logic [DATA_W-1:0] rf [8];
   logic [2:0]        op, rs, rt, rd, wa;
   logic [3:0]        func;

   assign op     = ir[15:13];
   assign rs     = ir[12:10];
   assign rt     = ir[9:7];
   assign rd     = ir[6:4];
   assign func   = ir[3:0];
   assign imm    = DATA_W'($signed(ir[6:0]));
   assign wa     = (op == OP_R) ? rd : rt;
   assign rf_rs  = (rs == 3'd0) ? '0 : rf[rs];
   assign rf_rt  = (rt == 3'd0) ? '0 : rf[rt];
   assign pc_inc = pc + PC_W'(1);
   assign br_tgt = (BRANCH_REL != 0) ? pc_inc + PC_W'($signed(ir[6:0])) : PC_W'(ir[6:0]);

   assign bus.imem_req   = rst_n && state == FETCH;
   assign bus.imem_addr  = pc;
   assign bus.dmem_req   = state == MEM;
   assign bus.dmem_we    = state == MEM && op == OP_SW;
   assign bus.dmem_addr  = res;
   assign bus.dmem_wdata = b;
   assign halted         = state == HALT;

   always_comb begin
      alu = a + imm;
      if (op == OP_R)
         case (func)
            4'd0:    alu = a + b;
            4'd1:    alu = a - b;
            4'd2:    alu = a & b;
            4'd3:    alu = a | b;
            4'd4:    alu = a ^ b;
            4'd5:    alu = {{(DATA_W-1){1'b0}}, a < b};
            4'd6:    alu = a << b[3:0];
            4'd7:    alu = a >> b[3:0];
            default: alu = '0;
         endcase
   end

   // retire is combinational so it lands in the instruction's final cycle, same edge as pc/instret
   always_comb begin
      state_n = state;
      retire  = 1'b0;
      pc_n    = pc_inc;
      case (state)
         FETCH:  state_n = bus.imem_ack ? DECODE : FETCH;
         DECODE: begin
            if (ir == 16'hFFFF) state_n = HALT;
            else if (op == OP_J) begin
               state_n = FETCH;
               retire  = 1'b1;
               pc_n    = PC_W'(ir[12:0]);
            end else state_n = EXEC;
         end
         EXEC: begin
            if (op == OP_LW || op == OP_SW) state_n = MEM;
            else if (op == OP_R || op == OP_ADDI) state_n = WB;
            else begin
               state_n = FETCH;
               retire  = 1'b1;
               pc_n    = (op == OP_BEQ && a == b) ? br_tgt : pc_inc;
            end
         end
         MEM: if (bus.dmem_ack) begin
            state_n = (op == OP_SW) ? FETCH : WB;
            retire  = op == OP_SW;
         end
         WB: begin
            state_n = FETCH;
            retire  = 1'b1;
         end
         default: state_n = HALT;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) state <= FETCH;
      else state <= state_n;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc      <= '0;
         instret <= '0;
         ir      <= '0;
         a       <= '0;
         b       <= '0;
         res     <= '0;
      end else begin
         if (state == FETCH && bus.imem_ack) ir <= bus.imem_rdata;
         if (state == DECODE) begin
            a <= rf_rs;
            b <= rf_rt;
         end
         if (state == EXEC) res <= alu;
         if (state == MEM && bus.dmem_ack && op == OP_LW) res <= bus.dmem_rdata;
         if (retire) begin
            pc      <= pc_n;
            instret <= instret + 32'd1;
         end
      end
   end

   // no reset on the register file; WB is unreachable while rst_n is low
   always_ff @(posedge clk)
      if (state == WB && wa != 3'd0) rf[wa] <= res;
endmodule

// File: tb/tb_multicycle_cpu.sv
// tb_multicycle_cpu: directed programs against 16-bit absolute, 16-bit relative and 32-bit cores.
module tb_multicycle_cpu;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;

   multicycle_cpu_if #(.DATA_W(16), .PC_W(13)) a_bus ();
   multicycle_cpu_if #(.DATA_W(16), .PC_W(13)) b_bus ();
   multicycle_cpu_if #(.DATA_W(32), .PC_W(13)) c_bus ();
   logic a_halted, a_retire, b_halted, b_retire, c_halted, c_retire;
   logic [31:0] a_instret, b_instret, c_instret;

   multicycle_cpu #(.DATA_W(16), .PC_W(13), .BRANCH_REL(0)) dut_a (
      .clk(clk), .rst_n(rst_n), .bus(a_bus), .halted(a_halted), .retire(a_retire), .instret(a_instret));
   multicycle_cpu #(.DATA_W(16), .PC_W(13), .BRANCH_REL(1)) dut_b (
      .clk(clk), .rst_n(rst_n), .bus(b_bus), .halted(b_halted), .retire(b_retire), .instret(b_instret));
   multicycle_cpu #(.DATA_W(32), .PC_W(13), .BRANCH_REL(0)) dut_c (
      .clk(clk), .rst_n(rst_n), .bus(c_bus), .halted(c_halted), .retire(c_retire), .instret(c_instret));

   // main core memories with programmable wait states
   logic [15:0] imem_a [8192];
   logic [15:0] dmem_a [256];
   int iwait = 0, dwait = 0, icnt = 0, dcnt = 0;
   always @(posedge clk) begin
      icnt <= (a_bus.imem_req && !a_bus.imem_ack) ? icnt + 1 : 0;
      dcnt <= (a_bus.dmem_req && !a_bus.dmem_ack) ? dcnt + 1 : 0;
      if (a_bus.dmem_req && a_bus.dmem_ack && a_bus.dmem_we) dmem_a[a_bus.dmem_addr[7:0]] <= a_bus.dmem_wdata;
   end
   assign a_bus.imem_ack   = a_bus.imem_req && icnt == iwait;
   assign a_bus.imem_rdata = imem_a[a_bus.imem_addr];
   assign a_bus.dmem_ack   = a_bus.dmem_req && dcnt == dwait;
   assign a_bus.dmem_rdata = dmem_a[a_bus.dmem_addr[7:0]];

   logic [15:0] imem_b [32];
   logic [15:0] imem_c [32];
   assign b_bus.imem_ack   = b_bus.imem_req;
   assign b_bus.imem_rdata = imem_b[b_bus.imem_addr[4:0]];
   assign b_bus.dmem_ack   = b_bus.dmem_req;
   assign b_bus.dmem_rdata = '0;
   assign c_bus.imem_ack   = c_bus.imem_req;
   assign c_bus.imem_rdata = imem_c[c_bus.imem_addr[4:0]];
   assign c_bus.dmem_ack   = c_bus.dmem_req;
   assign c_bus.dmem_rdata = '0;

   int cyc = 0;
   always @(posedge clk) cyc <= rst_n ? cyc + 1 : 0;

   int ret_cyc [64];
   int fetch_log [64];
   int nret, nfetch, dreq_run, dreq_last;
   logic dreq_unstable;
   logic [15:0] dreq_addr;
   logic [31:0] c_wdata;
   always @(negedge clk) begin
      if (!rst_n) begin
         nret = 0; nfetch = 0; dreq_run = 0; dreq_last = 0; dreq_unstable = 1'b0; c_wdata = '0;
      end else begin
         if (a_retire && nret < 64) begin ret_cyc[nret] = cyc; nret++; end
         if (a_bus.imem_req && a_bus.imem_ack && nfetch < 64) begin fetch_log[nfetch] = int'(a_bus.imem_addr); nfetch++; end
         if (a_bus.dmem_req) begin
            if (dreq_run == 0) dreq_addr = a_bus.dmem_addr;
            else if (a_bus.dmem_addr !== dreq_addr) dreq_unstable = 1'b1;
            dreq_run++;
         end else if (dreq_run > 0) begin
            dreq_last = dreq_run;
            dreq_run = 0;
         end
         if (c_bus.dmem_req && c_bus.dmem_ack && c_bus.dmem_we) c_wdata = c_bus.dmem_wdata;
      end
   end

   function automatic logic [15:0] enc_r(int rs, int rt, int rd, int fn);
      return {3'b000, 3'(rs), 3'(rt), 3'(rd), 4'(fn)};
   endfunction
   function automatic logic [15:0] enc_i(int op, int rs, int rt, int imm);
      return {3'(op), 3'(rs), 3'(rt), 7'(imm)};
   endfunction
   function automatic logic [15:0] enc_j(int addr);
      return {3'b101, 13'(addr)};
   endfunction

   task automatic clear_mem();
      for (int i = 0; i < 8192; i++) imem_a[i] = 16'hFFFF;
      for (int i = 0; i < 256; i++) dmem_a[i] = 16'h0000;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
   endtask

   task automatic run_until_halt(input int max, input string name);
      for (int i = 0; i < max && !a_halted; i++) @(negedge clk);
      tests++;
      if (!a_halted) begin fails++; $display("FAIL %s halt_timeout halted=%0b required=1", name, a_halted); end
   endtask

   task automatic test_reset();
      clear_mem();
      rst_n = 1'b0;
      @(negedge clk);
      tests += 6;
      if (a_halted !== 1'b0) begin fails++; $display("FAIL reset_halted got=%0b exp=0", a_halted); end
      if (a_retire !== 1'b0) begin fails++; $display("FAIL reset_retire got=%0b exp=0", a_retire); end
      if (a_bus.dmem_req !== 1'b0) begin fails++; $display("FAIL reset_dmem_req got=%0b exp=0", a_bus.dmem_req); end
      if (a_bus.dmem_we !== 1'b0) begin fails++; $display("FAIL reset_dmem_we got=%0b exp=0", a_bus.dmem_we); end
      if (a_instret !== 32'd0) begin fails++; $display("FAIL reset_instret got=%0d exp=0", a_instret); end
      if (a_bus.imem_req !== 1'b0) begin fails++; $display("FAIL reset_imem_req got=%0b exp=0", a_bus.imem_req); end
      @(posedge clk);
      #1 rst_n = 1'b1;
      @(negedge clk);
      tests += 2;
      if (a_bus.imem_req !== 1'b1) begin fails++; $display("FAIL reset_first_fetch got=%0b exp=1", a_bus.imem_req); end
      if (a_bus.imem_addr !== 13'd0) begin fails++; $display("FAIL reset_pc got=%0h exp=0", a_bus.imem_addr); end
   endtask

   task automatic test_alu();
      clear_mem();
      imem_a[0]  = enc_i(1, 0, 1, 5);
      imem_a[1]  = enc_i(1, 0, 2, -3);
      imem_a[2]  = enc_r(1, 2, 3, 0);
      imem_a[3]  = enc_r(1, 2, 4, 1);
      imem_a[4]  = enc_r(1, 2, 5, 5);
      imem_a[5]  = enc_i(1, 0, 6, 1);
      imem_a[6]  = enc_i(1, 0, 7, 15);
      imem_a[7]  = enc_r(6, 7, 6, 6);
      imem_a[8]  = enc_i(3, 0, 3, 0);
      imem_a[9]  = enc_i(3, 0, 4, 1);
      imem_a[10] = enc_i(3, 0, 5, 2);
      imem_a[11] = enc_i(3, 0, 6, 3);
      do_reset();
      run_until_halt(200, "alu");
      tests += 5;
      if (dmem_a[0] !== 16'd2) begin fails++; $display("FAIL alu_add got=%0h exp=2", dmem_a[0]); end
      if (dmem_a[1] !== 16'd8) begin fails++; $display("FAIL alu_sub got=%0h exp=8", dmem_a[1]); end
      if (dmem_a[2] !== 16'd1) begin fails++; $display("FAIL alu_sltu got=%0h exp=1", dmem_a[2]); end
      if (dmem_a[3] !== 16'h8000) begin fails++; $display("FAIL alu_sll got=%0h exp=8000", dmem_a[3]); end
      if (a_instret !== 32'd12) begin fails++; $display("FAIL alu_instret got=%0d exp=12", a_instret); end
      for (int i = 0; i < 12; i++) begin
         tests++;
         if (ret_cyc[i] !== 4 * i + 3) begin fails++; $display("FAIL alu_retire_cycle[%0d] got=%0d exp=%0d", i, ret_cyc[i], 4 * i + 3); end
      end
   endtask

   task automatic test_mem_wait();
      clear_mem();
      imem_a[0] = enc_i(1, 0, 1, 5);
      imem_a[1] = enc_i(3, 0, 1, 10);
      imem_a[2] = enc_i(2, 0, 4, 10);
      imem_a[3] = enc_i(3, 0, 4, 11);
      iwait = 3;
      dwait = 3;
      do_reset();
      run_until_halt(300, "mem_wait");
      tests += 6;
      if (dmem_a[11] !== 16'd5) begin fails++; $display("FAIL mem_lw_value got=%0h exp=5", dmem_a[11]); end
      if (ret_cyc[0] !== 6) begin fails++; $display("FAIL mem_addi_cycle got=%0d exp=6", ret_cyc[0]); end
      if (ret_cyc[1] - ret_cyc[0] !== 10) begin fails++; $display("FAIL mem_sw_cpi got=%0d exp=10", ret_cyc[1] - ret_cyc[0]); end
      if (ret_cyc[2] - ret_cyc[1] !== 11) begin fails++; $display("FAIL mem_lw_cpi got=%0d exp=11", ret_cyc[2] - ret_cyc[1]); end
      if (dreq_last !== 4) begin fails++; $display("FAIL mem_req_len got=%0d exp=4", dreq_last); end
      if (dreq_unstable !== 1'b0) begin fails++; $display("FAIL mem_addr_stable got=%0b exp=0", dreq_unstable); end
      iwait = 0;
      dwait = 0;
   endtask

   task automatic test_branch();
      clear_mem();
      imem_a[0] = enc_i(1, 0, 1, 3);
      imem_a[1] = enc_i(1, 0, 2, 3);
      imem_a[2] = enc_i(4, 1, 2, 7);
      imem_a[7] = enc_i(4, 1, 0, 20);
      do_reset();
      run_until_halt(100, "branch");
      tests += 4;
      if (fetch_log[3] !== 7) begin fails++; $display("FAIL beq_taken_pc got=%0d exp=7", fetch_log[3]); end
      if (fetch_log[4] !== 8) begin fails++; $display("FAIL beq_not_taken_pc got=%0d exp=8", fetch_log[4]); end
      if (ret_cyc[2] - ret_cyc[1] !== 3) begin fails++; $display("FAIL beq_cpi got=%0d exp=3", ret_cyc[2] - ret_cyc[1]); end
      if (a_instret !== 32'd4) begin fails++; $display("FAIL beq_instret got=%0d exp=4", a_instret); end
   endtask

   task automatic test_jump_r0();
      clear_mem();
      imem_a[0]       = enc_j(16'h1ABC);
      imem_a[16'h1ABC] = enc_i(1, 0, 0, 9);
      imem_a[16'h1ABD] = enc_r(0, 0, 5, 0);
      imem_a[16'h1ABE] = enc_i(3, 0, 5, 12);
      dmem_a[12] = 16'hFFFF;
      do_reset();
      run_until_halt(100, "jump");
      tests += 3;
      if (fetch_log[1] !== 32'h1ABC) begin fails++; $display("FAIL jump_pc got=%0h exp=1abc", fetch_log[1]); end
      if (dmem_a[12] !== 16'd0) begin fails++; $display("FAIL r0_write_ignored got=%0h exp=0", dmem_a[12]); end
      if (ret_cyc[0] !== 1) begin fails++; $display("FAIL jump_cpi got=%0d exp=1", ret_cyc[0]); end
   endtask

   task automatic test_halt();
      int nreq;
      clear_mem();
      imem_a[0] = enc_i(1, 0, 1, 1);
      imem_a[1] = enc_i(1, 1, 1, 1);
      imem_a[2] = 16'hC000;
      do_reset();
      run_until_halt(100, "halt");
      tests++;
      if (a_instret !== 32'd3) begin fails++; $display("FAIL halt_instret got=%0d exp=3", a_instret); end
      nreq = 0;
      repeat (20) @(negedge clk) if (a_bus.imem_req || a_retire || !a_halted) nreq++;
      tests++;
      if (nreq !== 0) begin fails++; $display("FAIL halt_quiet got=%0d exp=0", nreq); end
      rst_n = 1'b0;
      @(negedge clk);
      tests += 2;
      if (a_instret !== 32'd0) begin fails++; $display("FAIL halt_reset_instret got=%0d exp=0", a_instret); end
      if (a_halted !== 1'b0) begin fails++; $display("FAIL halt_reset_halted got=%0b exp=0", a_halted); end
      @(posedge clk);
      #1 rst_n = 1'b1;
      @(negedge clk);
      tests++;
      if (!(a_bus.imem_req === 1'b1 && a_bus.imem_addr === 13'd0)) begin
         fails++; $display("FAIL halt_restart req=%0b addr=%0h exp req=1 addr=0", a_bus.imem_req, a_bus.imem_addr);
      end
   endtask

   task automatic test_reset_mid_mem();
      int seen;
      clear_mem();
      imem_a[0] = enc_i(1, 0, 4, 7);
      imem_a[1] = enc_i(2, 0, 4, 10);
      dmem_a[10] = 16'h0055;
      dwait = 20;
      do_reset();
      seen = 0;
      for (int i = 0; i < 50 && seen == 0; i++) begin
         @(negedge clk);
         if (a_bus.dmem_req) seen = 1;
      end
      tests++;
      if (seen !== 1) begin fails++; $display("FAIL midmem_req_seen got=%0d exp=1", seen); end
      repeat (2) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      tests++;
      if (a_bus.dmem_req !== 1'b0) begin fails++; $display("FAIL midmem_req_drop got=%0b exp=0", a_bus.dmem_req); end
      clear_mem();
      imem_a[0] = enc_i(3, 0, 4, 13);
      dwait = 0;
      @(posedge clk);
      #1 rst_n = 1'b1;
      run_until_halt(100, "midmem");
      tests += 2;
      if (dmem_a[13] !== 16'd7) begin fails++; $display("FAIL midmem_reg_kept got=%0h exp=7", dmem_a[13]); end
      if (fetch_log[0] !== 0) begin fails++; $display("FAIL midmem_restart_pc got=%0d exp=0", fetch_log[0]); end
   endtask

   task automatic test_branch_rel();
      for (int i = 0; i < 50 && !b_halted; i++) @(negedge clk);
      tests += 2;
      if (b_bus.imem_addr !== 13'd16) begin fails++; $display("FAIL rel_branch_pc got=%0d exp=16", b_bus.imem_addr); end
      if (b_instret !== 32'd2) begin fails++; $display("FAIL rel_instret got=%0d exp=2", b_instret); end
   endtask

   task automatic test_data_w32();
      for (int i = 0; i < 50 && !c_halted; i++) @(negedge clk);
      tests++;
      if (c_wdata !== 32'hFFFFFFFF) begin fails++; $display("FAIL w32_addi_neg got=%0h exp=ffffffff", c_wdata); end
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int i = 0; i < 32; i++) begin imem_b[i] = 16'hFFFF; imem_c[i] = 16'hFFFF; end
      imem_b[0]  = enc_j(20);
      imem_b[20] = enc_i(4, 0, 0, -5);
      imem_c[0]  = enc_i(1, 0, 1, -1);
      imem_c[1]  = enc_i(3, 0, 1, 0);
      test_reset();
      test_alu();
      test_mem_wait();
      test_branch();
      test_jump_r0();
      test_halt();
      test_reset_mid_mem();
      test_branch_rel();
      test_data_w32();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
